// File: rtl/tinyalu_drv_pkg.sv
// Shared opcode/state types, command struct and default sizing for the tinyalu command driver.
package tinyalu_drv_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_TIMEOUT = 15;

  // Any opcode with bit 2 set is a multiply; MUL is the canonical encoding.
  typedef enum logic [2:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]           a;
    logic [7:0]           b;
    logic [2:0]           op;
    logic [DEF_TAG_W-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous FIFO of command structs; head_o is valid whenever empty_o is low.
// full_o/empty_o come from the registered count, so they never see a same-cycle push or pop.
module tinyalu_cmd_fifo
  import tinyalu_drv_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  T     push_dat_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// tinyalu front end: buffers commands, drops no-ops, issues one at a time, holds each response.
// Define TINYALU_DRV_TIMEOUT_EN to add a watchdog that aborts a hung ALU with rsp_err=1.
module tinyalu_cmd_driver
  import tinyalu_drv_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [15:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  // Same layout as cmd_t, but with the tag sized by this instance's TAG_W.
  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_w_t;

  cmd_w_t           cmd_in;
  cmd_w_t           head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  state_e           state_q, state_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_start_q, alu_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             wd_expired;

`ifdef TINYALU_DRV_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
  logic       rsp_err_q, rsp_err_d;
  assign wd_expired = (wd_q == WD_LAST);
  assign rsp_err    = rsp_err_q;
`else
  assign wd_expired = 1'b0;
  assign rsp_err    = 1'b0;
  // TIMEOUT has no effect without the watchdog.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  assign cmd_ready = !fifo_full;

  tinyalu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_valid),
    .push_dat_i (cmd_in),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
`ifdef TINYALU_DRV_TIMEOUT_EN
      wd_q         <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
`ifdef TINYALU_DRV_TIMEOUT_EN
      wd_q         <= wd_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty && head.op != NO_OP) state_d = ISSUE;
      ISSUE:   if (alu_done || wd_expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop     = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = alu_start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
`ifdef TINYALU_DRV_TIMEOUT_EN
    wd_d         = wd_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        // No-ops are popped here and never reach the ALU.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.op != NO_OP) begin
            alu_a_d     = head.a;
            alu_b_d     = head.b;
            alu_op_d    = head.op;
            rsp_tag_d   = head.tag;
            alu_start_d = 1'b1;
`ifdef TINYALU_DRV_TIMEOUT_EN
            wd_d        = '0;
`endif
          end
        end
      end
      ISSUE: begin
`ifdef TINYALU_DRV_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        // A done on the expiry cycle takes priority over the abort.
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
`ifdef TINYALU_DRV_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
        end else if (wd_expired) begin
          rsp_result_d = '0;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
`ifdef TINYALU_DRV_TIMEOUT_EN
          rsp_err_d    = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Bench for tinyalu_cmd_driver: behavioural ALU, response scoreboard, directed and random traffic.
module tb_tinyalu_cmd_driver;

  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  tinyalu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        sb_q[$];
  logic [15:0] rsp_log[$];
  int          rise_q[$];
  logic        alu_stuck;
  logic        rnd_rdy_en;
  int          alu_cnt;
  logic        held;
  logic [15:0] held_res;
  logic [3:0]  held_tag;
  logic        prev_start;
  exp_t        e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return 16'h0000;
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      default: return {8'h00, a} * {8'h00, b};
    endcase
  endfunction

  // Behavioural tinyalu: done one cycle after start is seen (four for mul), low once start drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_cnt    <= 0;
      alu_done   <= 1'b0;
      alu_result <= 16'h0;
    end else if (!alu_start) begin
      alu_cnt  <= 0;
      alu_done <= 1'b0;
    end else begin
      alu_cnt <= alu_cnt + 1;
      if (!alu_stuck && (alu_cnt + 1) >= (alu_op[2] ? 4 : 1)) begin
        alu_done   <= 1'b1;
        alu_result <= ref_calc(alu_a, alu_b, alu_op);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy_en) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: values seen at the falling edge are what the next rising edge acts on.
  always @(negedge clk) begin
    if (reset) begin
      held       = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready && cmd_op != 3'b000) begin
        e.res = alu_stuck ? 16'h0 : ref_calc(cmd_a, cmd_b, cmd_op);
        e.tag = cmd_tag;
        e.err = alu_stuck;
        sb_q.push_back(e);
      end
      if (held) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, held_res);
        chk("hold_tag", rsp_tag, held_tag);
      end
      held     = rsp_valid && !rsp_ready;
      held_res = rsp_result;
      held_tag = rsp_tag;
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(rsp_result);
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_result", rsp_result, e.res);
          chk("sb_tag", rsp_tag, e.tag);
          chk("sb_err", rsp_err, e.err);
        end
      end
      if (alu_start && !prev_start) rise_q.push_back(cyc);
      prev_start = alu_start;
    end
  end

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [3:0] tag);
    int   n;
    logic ok;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    n         = 0;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    if (!ok) chk("send_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || rsp_valid || alu_start) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", (sb_q.size() == 0 && !rsp_valid && !alu_start) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int         n;
    int         nlog;
    int         nrise;
    int         n_nonnoop;
    logic [2:0] op3;
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rsp_ready = 1'b1; alu_stuck = 1'b0; rnd_rdy_en = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    send_cmd(8'hFF, 8'h01, 3'b001, 4'd3);
    wait_rsp(n);
    chk("add_latency", n, 3);
    chk("add_result", rsp_result, 16'h0100);
    chk("add_tag", rsp_tag, 4'd3);
    chk("add_err", rsp_err, 0);
    @(posedge clk);
    #1;

    send_cmd(8'hFF, 8'hFF, 3'b100, 4'd5);
    wait_rsp(n);
    chk("mul_latency", n, 6);
    chk("mul_result", rsp_result, 16'hFE01);
    @(posedge clk);
    #1;

    rise_q.delete();
    send_cmd(8'h11, 8'h22, 3'b001, 4'd1);
    send_cmd(8'h33, 8'h44, 3'b001, 4'd2);
    drain();
    chk("add_rises", rise_q.size(), 2);
    if (rise_q.size() >= 2) chk("add_interval", rise_q[1] - rise_q[0], 4);

    rise_q.delete();
    send_cmd(8'h12, 8'h34, 3'b110, 4'd6);
    send_cmd(8'h56, 8'h78, 3'b101, 4'd7);
    drain();
    chk("mul_rises", rise_q.size(), 2);
    if (rise_q.size() >= 2) chk("mul_interval", rise_q[1] - rise_q[0], 7);

    nlog = rsp_log.size();
    send_cmd(8'hF0, 8'h3C, 3'b011, 4'd1);
    send_cmd(8'hAA, 8'h55, 3'b000, 4'd2);
    send_cmd(8'hF0, 8'h3C, 3'b010, 4'd3);
    drain();
    chk("noop_rsp_count", rsp_log.size() - nlog, 2);
    if (rsp_log.size() >= nlog + 2) begin
      chk("noop_first", rsp_log[nlog], 16'h00CC);
      chk("noop_second", rsp_log[nlog+1], 16'h0030);
    end

    // One command parks in RESP, DEPTH more fill the FIFO.
    rsp_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      send_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(1, 7)), 4'(i));
    @(negedge clk);
    chk("burst_full", cmd_ready, 0);
    repeat (8) @(negedge clk);
    chk("burst_still_full", cmd_ready, 0);
    chk("burst_held_valid", rsp_valid, 1);
    chk("burst_held_tag", rsp_tag, 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send_cmd(8'($urandom), 8'($urandom), 3'b001, 4'(DEPTH + 1));
    drain();

    nlog = rsp_log.size();
    send_cmd(8'h12, 8'h34, 3'b100, 4'h9);
    send_cmd(8'h01, 8'h02, 3'b001, 4'hA);
    chk("rst_pre_start", alu_start, 1);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mrst_alu_start", alu_start, 0);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_b", alu_b, 0);
    chk("mrst_alu_op", alu_op, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_rsp_result", rsp_result, 0);
    chk("mrst_rsp_tag", rsp_tag, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    nrise = rise_q.size();
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_no_rsp", rsp_log.size() - nlog, 0);
    chk("mrst_no_issue", rise_q.size() - nrise, 0);
    chk("mrst_ready_after", cmd_ready, 1);

    rnd_rdy_en = 1'b1;
    n_nonnoop  = 0;
    nlog       = rsp_log.size();
    for (int i = 0; i < 150; i++) begin
      op3 = 3'($urandom_range(0, 7));
      if (op3 != 3'b000) n_nonnoop++;
      send_cmd(8'($urandom), 8'($urandom), op3, 4'(i));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("rnd_rsp_count", rsp_log.size() - nlog, n_nonnoop);
    rnd_rdy_en = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;

`ifdef TINYALU_DRV_TIMEOUT_EN
    alu_stuck = 1'b1;
    send_cmd(8'h10, 8'h20, 3'b001, 4'hC);
    wait_rsp(n);
    chk("to_latency", n, TO + 1);
    chk("to_err", rsp_err, 1);
    chk("to_result", rsp_result, 0);
    chk("to_tag", rsp_tag, 4'hC);
    drain();
    alu_stuck = 1'b0;
    send_cmd(8'h10, 8'h20, 3'b001, 4'hD);
    wait_rsp(n);
    chk("post_to_latency", n, 3);
    chk("post_to_result", rsp_result, 16'h0030);
    chk("post_to_err", rsp_err, 0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
